bkm_data_step_stimulus: RTL
===========================

Name: bkm_data_step_stimulus

Overview:
Stimulus and golden-model generator for the bkm_data_step datapath and its checker.
- On a start pulse it sweeps the step index n over 0..2^LOG2N-1 and emits NVEC vectors per n.
- Each vector carries operands X_n, Y_n, digits d_x_n, d_y_n and the expected X_np1, Y_np1, with a valid strobe.
- It drives the tb_* inputs of the DUT and the checker; the sweep is fully self-contained and needs no file I/O.

Parameters:
W, 64, datapath width, two's complement.
LOG2N, 6, width of n; the sweep covers 2^LOG2N steps.
NVEC, 16, vectors emitted per value of n (≥1).

Ports:
clk  in  1  clock
arst  in  1  asynchronous reset, active-high
srst  in  1  synchronous clear, active-high; same effect as arst but at the clock edge
enable  in  1  clock enable; when low all state holds and tb_valid is forced low
start  in  1  single-cycle pulse; starts a sweep from IDLE or DONE
seed  in  32  LFSR seed, sampled on start
cfg_mode  in  1  mode for the whole sweep; 0 = rotation (E), 1 = conjugate (L)
cfg_format  in  2  passed through to tb_format, latched on start
busy  out  1  high in SEED and RUN
done  out  1  high in DONE until the next start
tb_valid  out  1  vector on the tb_* outputs is valid this cycle
tb_mode  out  1  latched cfg_mode
tb_format  out  2  latched cfg_format
tb_n  out  LOG2N  current step index
tb_d_x_n  out  2  x digit
tb_d_y_n  out  2  y digit
tb_X_n  out  W  operand X
tb_Y_n  out  W  operand Y
tb_X_np1  out  W  expected X result
tb_Y_np1  out  W  expected Y result
vec_cnt  out  32  total vectors emitted this sweep

Behaviour:
- Reset (arst or srst): state IDLE; every output is 0; LFSR = 32'h1.
- FSM states: IDLE, SEED, RUN, DONE. All transitions are qualified by enable=1.
  - IDLE/DONE to SEED on start. Latch seed (0 is replaced by 32'h1), cfg_mode and cfg_format; clear n, the per-n counter and vec_cnt; done goes low.
  - SEED to RUN after one cycle; the LFSR is loaded in SEED.
  - RUN emits one vector per enabled cycle; the first tb_valid comes 2 enabled cycles after start.
  - RUN to DONE after the vector with n = 2^LOG2N-1 and per-n count = NVEC-1.
  - start while busy is ignored.
- Outputs are all registered and change together with tb_valid.
- tb_valid is high only in RUN with enable=1. Otherwise the tb_* data holds its last value.
- LFSR: 32-bit Galois, polynomial 0x80200003, advanced once per emitted vector.
- Operands:
  - X_n = lfsr replicated and truncated to W bits.
  - Y_n = the same, using lfsr rotated left by 16.
- Digit encoding: 00 = 0, 01 = +1, 11 = -1.
  - d_x from lfsr[1:0], d_y from lfsr[3:2].
  - Code 10 is remapped to 00 before output, so 10 is never emitted.
- Golden arithmetic, all modulo 2^W:
  - t = X_n >>> n, u = Y_n >>> n (arithmetic shifts).
  - Mode 0: X_np1 = X_n + dx·t − dy·u; Y_np1 = Y_n + dy·t + dx·u.
  - Mode 1: X_np1 = X_n + dx·t + dy·u; Y_np1 = Y_n + dx·u − dy·t.
  - A digit times an operand is +operand, −operand or 0; no multiplier.
- Counter wrap: the per-n counter wraps to 0 and n increments on the same edge. n never wraps; the sweep ends instead.
- vec_cnt saturates at 2^32−1.
- Reset mid-RUN aborts immediately to IDLE. There is no partial done.
- enable low mid-RUN: the sweep resumes with no vector lost or duplicated.

Optional Feature:
BKM_STIM_DIRECTED_EN
- Defined: the LFSR is replaced by a directed corner sequence, indexed by k = per-n count mod 4.
  - X_n ∈ {0, 1, 2^(W−1)−1, −2^(W−1)}[k]; Y_n uses index (k+1) mod 4.
  - Digit pair cycles through (00,01), (01,11), (11,00), (01,01).
  - seed is ignored.
- Undefined: LFSR stimulus as above.

Decomposition:
- Shared package: digit encodings (DIG_ZERO, DIG_POS, DIG_NEG), FSM state constants, LFSR polynomial and default seed.
- One sub-module, bkm_data_step_golden: the combinational golden step, with inputs mode, n, dx, dy, X, Y and outputs X_np1, Y_np1. It is reused by future checkers.

Test Plan:
- Golden, mode 0: W=16, LOG2N=4, directed X=100, Y=50, n=0, dx=01, dy=00 -> X_np1=200, Y_np1=100.
- Golden, mode 0: X=−8, Y=4, n=2, dx=11, dy=01 -> X_np1=−7, Y_np1=1.
- Full sweep: LOG2N=2, NVEC=3, start with enable held high -> first tb_valid 2 cycles after start; 12 valid vectors; tb_n sequence 0,0,0,1,…,3; done high and vec_cnt=12.
- Enable gating: toggle enable 50% during the sweep above -> still exactly 12 valid vectors in the same order; tb_valid is never high while enable is low.
- Reset: assert arst after the 5th vector -> all outputs 0 immediately, state IDLE; a new start replays an identical sequence for the same seed.
- Seed 0: start with seed=0 -> output is bit-identical to a sweep run with seed=1; no digit code 10 appears across the full LOG2N=6 sweep.

Source files
------------

// File: rtl/bkm_data_step_stimulus_pkg.sv
// Shared definitions for the bkm_data_step stimulus generator and golden step:
// digit encodings, FSM states, LFSR polynomial/seed and small helpers.
package bkm_data_step_stimulus_pkg;

  localparam logic [1:0] DIG_ZERO = 2'b00;
  localparam logic [1:0] DIG_POS  = 2'b01;
  localparam logic [1:0] DIG_NEG  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEED = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [31:0] LFSR_POLY         = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED_DEFAULT = 32'h0000_0001;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

  // Code 10 has no meaning in the digit set; fold it to zero.
  function automatic logic [1:0] dig_sanitize(input logic [1:0] c);
    return (c == 2'b10) ? DIG_ZERO : c;
  endfunction

endpackage

// File: rtl/bkm_data_step_golden.sv
// Combinational golden model of one BKM data step (modulo 2^W).
// mode 0 = rotation (E), mode 1 = conjugate (L). Digits are {0,+1,-1},
// so every digit product is a select of +v, -v or 0.
module bkm_data_step_golden
  import bkm_data_step_stimulus_pkg::*;
#(
  parameter int W     = 64,
  parameter int LOG2N = 6
) (
  input  logic             mode,
  input  logic [LOG2N-1:0] n,
  input  logic [1:0]       dx,
  input  logic [1:0]       dy,
  input  logic [W-1:0]     X,
  input  logic [W-1:0]     Y,
  output logic [W-1:0]     X_np1,
  output logic [W-1:0]     Y_np1
);

  logic [W-1:0] t, u;

  function automatic logic [W-1:0] dmul(input logic [1:0] d, input logic [W-1:0] v);
    case (d)
      DIG_POS: dmul = v;
      DIG_NEG: dmul = -v;
      default: dmul = '0;
    endcase
  endfunction

  assign t = $signed(X) >>> n;
  assign u = $signed(Y) >>> n;

  // Step equations for both modes.
  always_comb begin
    if (!mode) begin
      X_np1 = X + dmul(dx, t) - dmul(dy, u);
      Y_np1 = Y + dmul(dy, t) + dmul(dx, u);
    end else begin
      X_np1 = X + dmul(dx, t) + dmul(dy, u);
      Y_np1 = Y + dmul(dx, u) - dmul(dy, t);
    end
  end

endmodule

// File: rtl/bkm_data_step_stimulus.sv
// Stimulus + expected-result generator for bkm_data_step.
// Sweeps n over 0..2^LOG2N-1 with NVEC vectors per n. All outputs are
// registered; tb_valid is additionally masked by enable so a held vector is
// seen exactly once by an enabled consumer.
// Optional build macro BKM_STIM_DIRECTED_EN: replaces the LFSR stimulus by a
// directed corner-value sequence (seed ignored).
module bkm_data_step_stimulus
  import bkm_data_step_stimulus_pkg::*;
#(
  parameter int W     = 64,
  parameter int LOG2N = 6,
  parameter int NVEC  = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             srst,
  input  logic             enable,
  input  logic             start,
  input  logic [31:0]      seed,
  input  logic             cfg_mode,
  input  logic [1:0]       cfg_format,
  output logic             busy,
  output logic             done,
  output logic             tb_valid,
  output logic             tb_mode,
  output logic [1:0]       tb_format,
  output logic [LOG2N-1:0] tb_n,
  output logic [1:0]       tb_d_x_n,
  output logic [1:0]       tb_d_y_n,
  output logic [W-1:0]     tb_X_n,
  output logic [W-1:0]     tb_Y_n,
  output logic [W-1:0]     tb_X_np1,
  output logic [W-1:0]     tb_Y_np1,
  output logic [31:0]      vec_cnt
);

  localparam int              KW     = (NVEC > 1) ? $clog2(NVEC) : 1;
  localparam logic [KW-1:0]    K_LAST = KW'(NVEC - 1);
  localparam logic [LOG2N-1:0] N_LAST = '1;

  state_e           state_q, state_d;
  logic [31:0]      lfsr_q, lfsr_d;
  logic             busy_q, busy_d, done_q, done_d, valid_q, valid_d;
  logic             mode_q, mode_d;
  logic [1:0]       format_q, format_d;
  logic [LOG2N-1:0] n_q, n_d;
  logic [KW-1:0]    k_q, k_d;
  logic [1:0]       dx_q, dx_d, dy_q, dy_d;
  logic [W-1:0]     x_q, x_d, y_q, y_d, xp_q, xp_d, yp_q, yp_d;
  logic [31:0]      cnt_q, cnt_d;

  logic [LOG2N-1:0] emit_n;
  logic [KW-1:0]    emit_k;
  logic             last_vec;
  logic [W-1:0]     stim_x, stim_y, gold_x, gold_y;
  logic [1:0]       stim_dx, stim_dy;

  // Index of the vector to emit next: (0,0) from SEED, else successor of the
  // vector currently presented (per-n counter wraps as n increments).
  always_comb begin
    if (state_q == ST_SEED) begin
      emit_n = '0;
      emit_k = '0;
    end else if (k_q == K_LAST) begin
      emit_n = n_q + LOG2N'(1);
      emit_k = '0;
    end else begin
      emit_n = n_q;
      emit_k = k_q + KW'(1);
    end
  end

  assign last_vec = (n_q == N_LAST) && (k_q == K_LAST);

`ifdef BKM_STIM_DIRECTED_EN
  logic [1:0] sel;

  function automatic logic [W-1:0] corner(input logic [1:0] i);
    case (i)
      2'd0:    corner = '0;
      2'd1:    corner = W'(1);
      2'd2:    corner = {1'b0, {(W-1){1'b1}}};
      default: corner = {1'b1, {(W-1){1'b0}}};
    endcase
  endfunction

  // Directed corners indexed by per-n count mod 4.
  always_comb begin
    sel    = 2'(emit_k);
    stim_x = corner(sel);
    stim_y = corner(sel + 2'd1);
    case (sel)
      2'd0:    {stim_dx, stim_dy} = {DIG_ZERO, DIG_POS};
      2'd1:    {stim_dx, stim_dy} = {DIG_POS,  DIG_NEG};
      2'd2:    {stim_dx, stim_dy} = {DIG_NEG,  DIG_ZERO};
      default: {stim_dx, stim_dy} = {DIG_POS,  DIG_POS};
    endcase
  end
`else
  logic [31:0] lfsr_rot;

  // Operands are the LFSR word (and its 16-bit rotation) tiled across W bits.
  always_comb begin
    lfsr_rot = {lfsr_q[15:0], lfsr_q[31:16]};
    stim_x   = W'({((W + 31) / 32){lfsr_q}});
    stim_y   = W'({((W + 31) / 32){lfsr_rot}});
    stim_dx  = dig_sanitize(lfsr_q[1:0]);
    stim_dy  = dig_sanitize(lfsr_q[3:2]);
  end
`endif

  bkm_data_step_golden #(.W(W), .LOG2N(LOG2N)) u_golden (
    .mode  (mode_q),
    .n     (emit_n),
    .dx    (stim_dx),
    .dy    (stim_dy),
    .X     (stim_x),
    .Y     (stim_y),
    .X_np1 (gold_x),
    .Y_np1 (gold_y)
  );

  // FSM and vector register next-state; nothing moves while enable is low.
  always_comb begin
    logic emit;
    emit     = 1'b0;
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    busy_d   = busy_q;
    done_d   = done_q;
    valid_d  = valid_q;
    mode_d   = mode_q;
    format_d = format_q;
    n_d      = n_q;
    k_d      = k_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    x_d      = x_q;
    y_d      = y_q;
    xp_d     = xp_q;
    yp_d     = yp_q;
    cnt_d    = cnt_q;
    if (enable) begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d  = ST_SEED;
            lfsr_d   = (seed == 32'h0) ? LFSR_SEED_DEFAULT : seed;
            mode_d   = cfg_mode;
            format_d = cfg_format;
            cnt_d    = '0;
            busy_d   = 1'b1;
            done_d   = 1'b0;
          end
        end
        ST_SEED: begin
          state_d = ST_RUN;
          emit    = 1'b1;
        end
        default: begin
          if (last_vec) begin
            state_d = ST_DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            emit = 1'b1;
          end
        end
      endcase
      if (emit) begin
        valid_d = 1'b1;
        n_d     = emit_n;
        k_d     = emit_k;
        dx_d    = stim_dx;
        dy_d    = stim_dy;
        x_d     = stim_x;
        y_d     = stim_y;
        xp_d    = gold_x;
        yp_d    = gold_y;
        lfsr_d  = lfsr_next(lfsr_q);
        cnt_d   = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
      end
    end
  end

  // State registers; srst mirrors arst at the clock edge.
  always_ff @(posedge clk or posedge arst) begin
    if (arst || srst) begin
      state_q  <= ST_IDLE;
      lfsr_q   <= LFSR_SEED_DEFAULT;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      mode_q   <= 1'b0;
      format_q <= '0;
      n_q      <= '0;
      k_q      <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      xp_q     <= '0;
      yp_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      mode_q   <= mode_d;
      format_q <= format_d;
      n_q      <= n_d;
      k_q      <= k_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      x_q      <= x_d;
      y_q      <= y_d;
      xp_q     <= xp_d;
      yp_q     <= yp_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign tb_valid  = valid_q & enable;
  assign tb_mode   = mode_q;
  assign tb_format = format_q;
  assign tb_n      = n_q;
  assign tb_d_x_n  = dx_q;
  assign tb_d_y_n  = dy_q;
  assign tb_X_n    = x_q;
  assign tb_Y_n    = y_q;
  assign tb_X_np1  = xp_q;
  assign tb_Y_np1  = yp_q;
  assign vec_cnt   = cnt_q;

endmodule
